// File: rtl/reg_native_pkg.sv
// Shared types and constants for the reg_native forwarding slice.
package reg_native_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } fwd_state_e;

   localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

   // Width of a counter that can hold 0..tc; at least one bit when the watchdog is disabled.
   function automatic int unsigned cnt_width(input int unsigned tc);
      return (tc == 0) ? 1 : $clog2(tc + 1);
   endfunction

endpackage

// File: rtl/reg_native_wdog.sv
// Watchdog counter for the WAIT phase of the forwarding slice.
// expire is high while the count sits on the terminal value; TIMEOUT_CYC=0 disables it.
module reg_native_wdog
   import reg_native_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic fsm_clk,
   input  logic fsm_rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned CW   = cnt_width(TIMEOUT_CYC);
   localparam int unsigned LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

   logic [CW-1:0] cnt;

   // Saturating wait counter, cleared on reset or at the start of each transaction.
   always_ff @(posedge fsm_clk) begin
      if (fsm_rst || clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Terminal-count decode.
   always_comb begin
      expire = (TIMEOUT_CYC != 0) && (cnt == CW'(LAST));
   end

endmodule

// File: rtl/reg_native_fwd_slice.sv
// Registered forwarding stage on the reg_native_if path: one outstanding
// transaction, registered downstream request, watchdog-guarded response.
module reg_native_fwd_slice
   import reg_native_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 64,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           TIMEOUT_CYC = 255,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA    = DATA_WIDTH'(DEFAULT_ERR_DATA)
) (
   input  logic                  fsm_clk,
   input  logic                  fsm_rst,
   input  logic                  soft_rst,
   input  logic                  req_vld,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  ack_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  ds_req_vld,
   output logic                  ds_wr_en,
   output logic                  ds_rd_en,
   output logic [ADDR_WIDTH-1:0] ds_addr,
   output logic [DATA_WIDTH-1:0] ds_wr_data,
   input  logic                  ds_ack_vld,
   input  logic [DATA_WIDTH-1:0] ds_rd_data,
   output logic                  timeout_o,
   output logic                  proto_err_o
);

   fwd_state_e state;
   fwd_state_e state_nxt;
   logic       req_ok;
   logic       wd_clr;
   logic       wd_en;
   logic       wd_expire;

   assign req_ok = req_vld && (wr_en ^ rd_en);

   reg_native_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .fsm_clk (fsm_clk),
      .fsm_rst (fsm_rst),
      .clr     (wd_clr),
      .en      (wd_en),
      .expire  (wd_expire)
   );

   // State register; soft_rst aborts any in-flight transaction.
   always_ff @(posedge fsm_clk) begin
      if (fsm_rst || soft_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a downstream ack on the terminal-count cycle beats the timeout.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req_vld) state_nxt = req_ok ? ISSUE : RESP;
         ISSUE:   state_nxt = ds_ack_vld ? RESP : WAIT;
         WAIT:    if (ds_ack_vld || wd_expire) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes and watchdog control decoded from state.
   always_comb begin
      ds_req_vld = (state == ISSUE) && !soft_rst;
      ack_vld    = (state == RESP) && !soft_rst;
      timeout_o  = (state == WAIT) && wd_expire && !ds_ack_vld && !soft_rst;
      wd_clr     = (state == ISSUE);
      wd_en      = (state == WAIT) && !ds_ack_vld;
   end

   // Downstream request capture and upstream response data.
   always_ff @(posedge fsm_clk) begin
      if (fsm_rst) begin
         ds_wr_en   <= 1'b0;
         ds_rd_en   <= 1'b0;
         ds_addr    <= '0;
         ds_wr_data <= '0;
         rd_data    <= '0;
      end else if (!soft_rst) begin
         unique case (state)
            IDLE: begin
               if (req_ok) begin
                  ds_wr_en   <= wr_en;
                  ds_rd_en   <= rd_en;
                  ds_addr    <= addr;
                  ds_wr_data <= wr_data;
               end else if (req_vld) begin
                  rd_data <= ERR_DATA;
               end
            end
            ISSUE: begin
               if (ds_ack_vld) rd_data <= ds_wr_en ? '0 : ds_rd_data;
            end
            WAIT: begin
               if (ds_ack_vld)     rd_data <= ds_wr_en ? '0 : ds_rd_data;
               else if (wd_expire) rd_data <= ERR_DATA;
            end
            default: ;
         endcase
      end
   end

   // Sticky protocol error: bad qualifiers, or a request while busy.
   always_ff @(posedge fsm_clk) begin
      if (fsm_rst) begin
         proto_err_o <= 1'b0;
      end else if (req_vld && ((state != IDLE) || !req_ok)) begin
         proto_err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_native_fwd_slice.sv
// Directed scoreboard bench for reg_native_fwd_slice (TIMEOUT_CYC = 4).
module tb_reg_native_fwd_slice;

   logic        clk = 1'b0;
   logic        fsm_rst;
   logic        soft_rst;
   logic        req_vld;
   logic        wr_en;
   logic        rd_en;
   logic [63:0] addr;
   logic [31:0] wr_data;
   logic        ack_vld;
   logic [31:0] rd_data;
   logic        ds_req_vld;
   logic        ds_wr_en;
   logic        ds_rd_en;
   logic [63:0] ds_addr;
   logic [31:0] ds_wr_data;
   logic        ds_ack_vld;
   logic [31:0] ds_rd_data;
   logic        timeout_o;
   logic        proto_err_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   reg_native_fwd_slice #(
      .ADDR_WIDTH  (64),
      .DATA_WIDTH  (32),
      .TIMEOUT_CYC (4),
      .ERR_DATA    (32'hDEAD_BEEF)
   ) dut (
      .fsm_clk     (clk),
      .fsm_rst     (fsm_rst),
      .soft_rst    (soft_rst),
      .req_vld     (req_vld),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .addr        (addr),
      .wr_data     (wr_data),
      .ack_vld     (ack_vld),
      .rd_data     (rd_data),
      .ds_req_vld  (ds_req_vld),
      .ds_wr_en    (ds_wr_en),
      .ds_rd_en    (ds_rd_en),
      .ds_addr     (ds_addr),
      .ds_wr_data  (ds_wr_data),
      .ds_ack_vld  (ds_ack_vld),
      .ds_rd_data  (ds_rd_data),
      .timeout_o   (timeout_o),
      .proto_err_o (proto_err_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a one-cycle request; returns in the cycle after the sampling edge.
   task automatic send(input logic w, input logic r, input logic [63:0] a, input logic [31:0] d);
      req_vld = 1'b1;
      wr_en   = w;
      rd_en   = r;
      addr    = a;
      wr_data = d;
      tick();
      req_vld = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
   endtask

   // Downstream ack for one cycle; returns in the cycle after it is sampled.
   task automatic slave_ack(input logic [31:0] d);
      ds_ack_vld = 1'b1;
      ds_rd_data = d;
      tick();
      ds_ack_vld = 1'b0;
      ds_rd_data = '0;
   endtask

   task automatic expect_ack(input string tag);
      logic [31:0] e;
      chk({tag, "_ack"}, 64'(ack_vld), 64'd1);
      chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_rdata"}, 64'(rd_data), 64'(e));
      end
   endtask

   // The three strobes must never overlap.
   always @(negedge clk) begin
      chk("mutex", 64'($countones({ack_vld, ds_req_vld, timeout_o}) <= 1), 64'd1);
   end

   initial begin
      int n;
      fsm_rst    = 1'b1;
      soft_rst   = 1'b0;
      req_vld    = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      addr       = '0;
      wr_data    = '0;
      ds_ack_vld = 1'b0;
      ds_rd_data = '0;
      tick();
      tick();
      fsm_rst = 1'b0;

      // reset state
      chk("rst_ack", 64'(ack_vld), 64'd0);
      chk("rst_rdata", 64'(rd_data), 64'd0);
      chk("rst_ds_req", 64'(ds_req_vld), 64'd0);
      chk("rst_ds_addr", ds_addr, 64'd0);
      chk("rst_ds_wdata", 64'(ds_wr_data), 64'd0);
      chk("rst_proto", 64'(proto_err_o), 64'd0);
      tick();

      // 1) write, slave acks 3 cycles after ds_req
      exp_q.push_back(32'h0);
      send(1'b1, 1'b0, 64'h10, 32'hFFFF_FFFF);
      chk("t1_ds_req", 64'(ds_req_vld), 64'd1);
      chk("t1_ds_addr", ds_addr, 64'h10);
      chk("t1_ds_wdata", 64'(ds_wr_data), 64'hFFFF_FFFF);
      chk("t1_ds_wr_en", 64'(ds_wr_en), 64'd1);
      chk("t1_ds_rd_en", 64'(ds_rd_en), 64'd0);
      tick();
      chk("t1_ds_req_once", 64'(ds_req_vld), 64'd0);
      tick();
      tick();
      chk("t1_ack_early", 64'(ack_vld), 64'd0);
      slave_ack(32'hA5A5_5A5A);
      expect_ack("t1");
      tick();
      chk("t1_ack_once", 64'(ack_vld), 64'd0);

      // 2) read, zero-latency slave
      exp_q.push_back(32'h1234_5678);
      send(1'b0, 1'b1, 64'h24, 32'h0);
      chk("t2_ds_req", 64'(ds_req_vld), 64'd1);
      chk("t2_ds_rd_en", 64'(ds_rd_en), 64'd1);
      slave_ack(32'h1234_5678);
      expect_ack("t2");
      tick();
      chk("t2_ack_once", 64'(ack_vld), 64'd0);

      // 3) silent slave -> timeout, late ack ignored, next txn fine
      exp_q.push_back(32'hDEAD_BEEF);
      send(1'b0, 1'b1, 64'h30, 32'h0);
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (timeout_o) begin
            n = i;
            break;
         end
      end
      chk("t3_timeout_lat", 64'(n), 64'd4);
      chk("t3_no_ack_at_to", 64'(ack_vld), 64'd0);
      tick();
      expect_ack("t3");
      chk("t3_to_once", 64'(timeout_o), 64'd0);
      tick();
      slave_ack(32'h5555_AAAA);
      chk("t3_late_ack", 64'(ack_vld), 64'd0);
      chk("t3_late_rdata", 64'(rd_data), 64'hDEAD_BEEF);
      tick();
      chk("t3_late_ack2", 64'(ack_vld), 64'd0);
      exp_q.push_back(32'h0);
      send(1'b1, 1'b0, 64'h44, 32'h0BAD_F00D);
      chk("t3_next_ds_req", 64'(ds_req_vld), 64'd1);
      chk("t3_next_ds_addr", ds_addr, 64'h44);
      slave_ack(32'h1111_1111);
      expect_ack("t3_next");
      tick();
      chk("t3_proto", 64'(proto_err_o), 64'd0);

      // 4) both qualifiers -> error response, sticky proto_err
      exp_q.push_back(32'hDEAD_BEEF);
      send(1'b1, 1'b1, 64'h88, 32'h99);
      chk("t4_ds_req", 64'(ds_req_vld), 64'd0);
      expect_ack("t4");
      chk("t4_proto", 64'(proto_err_o), 64'd1);
      chk("t4_ds_addr_kept", ds_addr, 64'h44);
      tick();
      chk("t4_ack_once", 64'(ack_vld), 64'd0);
      chk("t4_proto_sticky", 64'(proto_err_o), 64'd1);

      // 5a) soft_rst in WAIT
      send(1'b0, 1'b1, 64'h50, 32'h0);
      tick();
      soft_rst = 1'b1;
      tick();
      soft_rst = 1'b0;
      chk("t5_ack", 64'(ack_vld), 64'd0);
      chk("t5_ds_req", 64'(ds_req_vld), 64'd0);
      chk("t5_ds_addr_kept", ds_addr, 64'h50);
      chk("t5_proto_kept", 64'(proto_err_o), 64'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t5_quiet", 64'({ack_vld, timeout_o}), 64'd0);
      end
      exp_q.push_back(32'h0F0F_0F0F);
      send(1'b0, 1'b1, 64'h58, 32'h0);
      chk("t5_after_ds_req", 64'(ds_req_vld), 64'd1);
      slave_ack(32'h0F0F_0F0F);
      expect_ack("t5_after");
      tick();

      // 5b) fsm_rst mid-WAIT
      send(1'b1, 1'b0, 64'h60, 32'h77);
      tick();
      fsm_rst = 1'b1;
      tick();
      fsm_rst = 1'b0;
      chk("t5r_ack", 64'(ack_vld), 64'd0);
      chk("t5r_rdata", 64'(rd_data), 64'd0);
      chk("t5r_ds_req", 64'(ds_req_vld), 64'd0);
      chk("t5r_ds_wr_en", 64'(ds_wr_en), 64'd0);
      chk("t5r_ds_rd_en", 64'(ds_rd_en), 64'd0);
      chk("t5r_ds_addr", ds_addr, 64'd0);
      chk("t5r_ds_wdata", 64'(ds_wr_data), 64'd0);
      chk("t5r_timeout", 64'(timeout_o), 64'd0);
      chk("t5r_proto", 64'(proto_err_o), 64'd0);
      tick();

      // 6) ack on the terminal-count cycle wins over the timeout
      exp_q.push_back(32'hCAFE_F00D);
      send(1'b0, 1'b1, 64'h70, 32'h0);
      tick();
      tick();
      tick();
      tick();
      ds_ack_vld = 1'b1;
      ds_rd_data = 32'hCAFE_F00D;
      #1;
      chk("t6_no_timeout", 64'(timeout_o), 64'd0);
      tick();
      ds_ack_vld = 1'b0;
      ds_rd_data = '0;
      expect_ack("t6");
      chk("t6_no_timeout_resp", 64'(timeout_o), 64'd0);
      tick();
      chk("t6_ack_once", 64'(ack_vld), 64'd0);

      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: observed no completion expected completion");
      $fatal(1);
   end

endmodule
